// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared types and constants for the store buffer
package store_buffer_pkg;

    typedef struct packed {
        logic [29:0] word_addr;
        logic [31:0] data;
        logic [3:0]  be;
    } store_entry_t;

    localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/store_buffer_match.sv
// rtl/store_buffer_match.sv - one pending entry vs. a load word address and lane mask
import store_buffer_pkg::*;

module store_buffer_match (
    input  logic         entry_valid,
    input  store_entry_t entry,
    input  logic [29:0]  ld_word_addr,
    input  logic [3:0]   ld_be,
    output logic         hit
);

    assign hit = entry_valid && (entry.word_addr == ld_word_addr) && ((entry.be & ld_be) != BE_NONE);

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store FIFO between the store datapath and the data-memory write port
import store_buffer_pkg::*;

module store_buffer #(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [3:0]       st_be,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             ld_check_valid,
    input  logic [31:0]      ld_addr,
    input  logic [3:0]       ld_be,
    output logic             ld_hit,
    output logic [PTR_W:0]   count,
    output logic             empty
);

    localparam logic [PTR_W:0] ONE = {{PTR_W{1'b0}}, 1'b1};

    store_entry_t     entries_q [DEPTH];
    store_entry_t     entries_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [PTR_W-1:0] wr_idx, rd_idx;
    logic             full, enq, deq;
    logic [DEPTH-1:0] hit_vec;
    logic [3:0]       unused_addr_bits;

    assign wr_idx = wr_ptr_q[PTR_W-1:0];
    assign rd_idx = rd_ptr_q[PTR_W-1:0];
    assign full   = (wr_idx == rd_idx) && (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
    assign empty  = (wr_ptr_q == rd_ptr_q);

    // st_ready looks only at registered state so memory back-pressure never reaches the pipeline combinationally.
    assign st_ready      = !full;
    assign mem_req_valid = !empty;
    assign enq           = st_valid && st_ready && (st_be != BE_NONE);
    assign deq           = mem_req_valid && mem_req_ready;

    assign mem_addr  = {entries_q[rd_idx].word_addr, 2'b00};
    assign mem_wdata = entries_q[rd_idx].data;
    assign mem_be    = entries_q[rd_idx].be;
    assign count     = count_q;

    // Byte offsets are irrelevant: entries and the hazard check work at word granularity.
    assign unused_addr_bits = {st_addr[1:0], ld_addr[1:0]};

    always_comb begin
        entries_d = entries_q;
        valid_d   = valid_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (enq) begin
            entries_d[wr_idx] = '{word_addr: st_addr[31:2], data: st_data, be: st_be};
            valid_d[wr_idx]   = 1'b1;
            wr_ptr_d          = wr_ptr_q + ONE;
        end
        if (deq) begin
            valid_d[rd_idx] = 1'b0;
            rd_ptr_d        = rd_ptr_q + ONE;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        store_buffer_match u_match (
            .entry_valid  (valid_q[i]),
            .entry        (entries_q[i]),
            .ld_word_addr (ld_addr[31:2]),
            .ld_be        (ld_be),
            .hit          (hit_vec[i])
        );
    end

    assign ld_hit = ld_check_valid && (|hit_vec);

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Small in-order FIFO between the store datapath (execute/memory stage) and the data-memory write port.
- Accepts word-aligned store packets (address, replicated write data, byte enables) from the pipeline and drains them to data memory under a valid/ready handshake.
- Decouples the core from memory back-pressure.
- Provides a load-hazard check so younger loads can stall on overlapping pending stores, and a fence/drain indication.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), pointer index width; derived, not overridden.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- st_valid  input  1  store packet presented by the store datapath.
- st_ready  output  1  buffer can accept a packet this cycle.
- st_addr  input  32  byte address of store (ALU result).
- st_data  input  32  memory-aligned write data (byte/half already replicated).
- st_be  input  4  byte enables.
- mem_req_valid  output  1  head entry presented to data memory.
- mem_req_ready  input  1  data memory accepts write this cycle.
- mem_addr  output  32  word address of head entry, bits [1:0] = 0.
- mem_wdata  output  32  head entry data.
- mem_be  output  4  head entry byte enables.
- ld_check_valid  input  1  a load is querying the buffer.
- ld_addr  input  32  load byte address.
- ld_be  input  4  load byte lanes.
- ld_hit  output  1  load overlaps a pending store; core must stall.
- count  output  PTR_W+1  number of valid entries.
- empty  output  1  count == 0; used as fence-done.

Behaviour:
- Reset (rst=1 at edge):
  - write and read pointers = 0, all entry valid bits = 0, count = 0.
  - Outputs: empty = 1, st_ready = 1, mem_req_valid = 0, ld_hit = 0.
  - mem_addr, mem_wdata and mem_be are don't-care while mem_req_valid = 0; storage is not cleared.
  - Reset mid-drain discards all entries, including an unacknowledged head.
- Storage:
  - Circular array of {word_addr[31:2], data[31:0], be[3:0]}.
  - Pointers are PTR_W+1 bits with a wrap bit. Full when indices are equal and wrap bits differ; empty when both are equal.
- Enqueue:
  - Occurs on st_valid && st_ready; entry written at the write pointer, which advances and wraps modulo DEPTH.
  - st_ready = !full, purely from registered state.
  - No combinational path from mem_req_ready to st_ready, so a full buffer refuses an enqueue even while draining that cycle.
- Zero-enable store: st_valid with st_be == 4'b0000 is handshaken (consumed) but not written; pointers and count are unchanged.
- Dequeue:
  - mem_req_valid = !empty. mem_addr, mem_wdata and mem_be are driven from the head entry.
  - Head entry is stable while mem_req_valid && !mem_req_ready.
  - On mem_req_valid && mem_req_ready the read pointer advances.
- Latency and throughput:
  - A store enqueued at edge N is visible on mem_req_valid after edge N (earliest memory accept at edge N+1).
  - Sustained throughput is 1 store/cycle with simultaneous enqueue and dequeue.
- count:
  - +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
  - Never exceeds DEPTH and never underflows.
- ld_hit (combinational, registered sources only):
  - ld_check_valid && OR over valid entries of (entry.word_addr == ld_addr[31:2] && (entry.be & ld_be) != 0).
  - Does not consider the packet being enqueued in the same cycle.
  - The head entry counts as pending until its acceptance edge.
- Ordering: strictly FIFO. No merging, no store-to-load forwarding.

Decomposition:
- Shared core package: typedef store_entry_t {logic [29:0] word_addr; logic [31:0] data; logic [3:0] be;}, and constant BE_NONE = 4'b0000.
- Byte-enable encoding (SB/SH/SW lane patterns) stays owned by the store datapath.
- No sub-module required. Optionally factor the hit comparator as store_buffer_match (one entry vs. ld_addr/ld_be), instantiated DEPTH times.

Test Plan:
- Reset, then SW addr=0x100 data=0xDEADBEEF be=1111 with mem_req_ready=1 → mem_req_valid=1 next cycle, mem_addr=0x100, mem_be=1111; count back to 0 after accept.
- mem_req_ready=0, issue 5 stores with DEPTH=4 → st_ready=0 after 4th accept, count=4, 5th held. Raise mem_req_ready → drain in order 0x0,0x4,0x8,0xC, then 5th accepted; never count>4.
- Full buffer with mem_req_ready=1 and st_valid=1 → that cycle: dequeue only, count 4→3; enqueue accepted the following cycle.
- Pending SB addr=0x203 be=1000 → load ld_addr=0x200 ld_be=0001 gives ld_hit=0; ld_be=1000 gives ld_hit=1; ld_addr=0x204 ld_be=1111 gives ld_hit=0.
- st_be=0000 with st_valid=1 → st_ready=1, count unchanged, no memory request.
- 3 entries pending, head stalled, assert rst one cycle → next cycle empty=1, mem_req_valid=0, count=0; a new store is then accepted normally.
